// File: rtl/wdg_timer.sv
// Programmable windowed watchdog: prescaled tick counter, keyed kick, sticky timeout.
// Configured through a single-cycle register port; only sys_res clears a timeout.
module wdg_timer #(
    parameter int          CNT_W           = 32,
    parameter int          PRESCALE        = 1024,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd1000,
    parameter int          WARN_TICKS      = 16,
    parameter logic [31:0] KICK_KEY        = 32'hA5C3_5A3C
) (
    input  logic        clk,
    input  logic        sys_res,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        warn,
    output logic        wdg_to
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W:0]   WARN_EXT = (CNT_W + 1)'(WARN_TICKS);

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_TIMEOUT = 2'd1;
    localparam logic [1:0] A_WINDOW  = 2'd2;
    localparam logic [1:0] A_KICK    = 2'd3;

    logic             r_en;
    logic             r_win_en;
    logic             r_lock;
    logic             r_to;
    logic [CNT_W-1:0] r_timeout;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_cnt;
    logic [PRE_W-1:0] r_pre;
    logic [31:0]      r_rdata;

    logic             w_active;
    logic             w_tick;
    logic             w_cfg_wr;
    logic             w_kick;
    logic             w_kick_ok;
    logic             w_stop;
    logic [31:0]      w_rd_mux;

    always_comb begin
        w_active  = r_en & ~r_to;
        w_tick    = w_active & (r_pre == PRE_MAX);
        // Config writes are blocked by LOCK and by a latched timeout.
        w_cfg_wr  = cfg_we & ~r_to & ~r_lock;
        w_kick    = cfg_we & w_active & (cfg_addr == A_KICK);
        w_kick_ok = (cfg_wdata == KICK_KEY) & (~r_win_en | (r_cnt >= r_window));
        w_stop    = w_cfg_wr & (cfg_addr == A_CTRL) & ~cfg_wdata[0];
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (cfg_addr)
            A_CTRL:    w_rd_mux = {29'd0, r_lock, r_win_en, r_en};
            A_TIMEOUT: w_rd_mux = 32'(r_timeout);
            A_WINDOW:  w_rd_mux = 32'(r_window);
            default:   w_rd_mux = 32'(r_cnt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_res) begin
            r_en      <= 1'b0;
            r_win_en  <= 1'b0;
            r_lock    <= 1'b0;
            r_to      <= 1'b0;
            r_timeout <= CNT_W'(DEFAULT_TIMEOUT);
            r_window  <= '0;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_rdata   <= 32'd0;
        end else begin
            if (w_cfg_wr) begin
                case (cfg_addr)
                    A_CTRL: begin
                        r_en     <= cfg_wdata[0];
                        r_win_en <= cfg_wdata[1];
                        r_lock   <= cfg_wdata[2];
                    end
                    A_TIMEOUT: r_timeout <= cfg_wdata[CNT_W-1:0];
                    A_WINDOW:  r_window  <= cfg_wdata[CNT_W-1:0];
                    default: ;
                endcase
            end

            // A kick takes priority over the tick that may land in the same cycle.
            if (w_kick) begin
                if (w_kick_ok) begin
                    r_cnt <= '0;
                    r_pre <= '0;
                end else begin
                    r_to <= 1'b1;
                end
            end else if (w_stop) begin
                r_cnt <= '0;
                r_pre <= '0;
            end else if (w_active) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
                if (w_tick) begin
                    if (r_cnt >= r_timeout) begin
                        r_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            if (cfg_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign cfg_rdata = r_rdata;
    assign wdg_to    = r_to;
    // Extra bit keeps cnt + WARN_TICKS from wrapping near the top of the range.
    assign warn      = r_en & ~r_to & (({1'b0, r_cnt} + WARN_EXT) >= {1'b0, r_timeout});

endmodule

// File: tb/tb_wdg_timer.sv
// Self-checking bench for wdg_timer: register reads are scored through an expectation queue,
// flag checks compare against cycle counts derived from the prescale/timeout settings.
module tb_wdg_timer;

    localparam logic [31:0] KEY = 32'hA5C3_5A3C;

    logic        clk;
    logic        sys_res;
    logic        cfg_we;
    logic        cfg_re;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        warn;
    logic        wdg_to;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    wdg_timer #(
        .CNT_W(16), .PRESCALE(4), .DEFAULT_TIMEOUT(32'd1000),
        .WARN_TICKS(2), .KICK_KEY(KEY)
    ) dut (
        .clk(clk), .sys_res(sys_res), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .warn(warn), .wdg_to(wdg_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys_res = 1'b1;
        idle(1);
        sys_res = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        idle(1);
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        exp_t x;
        cfg_re   = 1'b1;
        cfg_addr = a;
        x.tag = tag;
        x.val = e;
        sb_q.push_back(x);
        idle(1);
        cfg_re = 1'b0;
        x = sb_q.pop_front();
        chk(x.tag, cfg_rdata, x.val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        sys_res = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        #1;
        do_reset();

        // Reset values
        chk("rst_to", {31'd0, wdg_to}, 32'd0);
        chk("rst_warn", {31'd0, warn}, 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd1000, "rst_timeout");
        rd(2'd2, 32'd0, "rst_window");
        rd(2'd3, 32'd0, "rst_count");

        // Free-running timeout: TIMEOUT=3, PRESCALE=4 -> wdg_to at E0+16, warn from E0+4
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd1);
        chk("to_e0_warn", {31'd0, warn}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            chk($sformatf("to_k%0d_to", k), {31'd0, wdg_to}, (k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("to_k%0d_warn", k), {31'd0, warn}, (k >= 4 && k < 16) ? 32'd1 : 32'd0);
        end
        rd(2'd3, 32'd3, "to_count");
        wr(2'd3, KEY);
        wr(2'd1, 32'd50);
        rd(2'd1, 32'd3, "to_frozen_timeout");
        idle(20);
        chk("to_sticky", {31'd0, wdg_to}, 32'd1);
        do_reset();
        chk("to_cleared", {31'd0, wdg_to}, 32'd0);

        // Periodic valid kicks keep the watchdog quiet
        wr(2'd1, 32'd10);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 33; i++) begin
            idle(28);
            wr(2'd3, KEY);
            rd(2'd3, 32'd0, $sformatf("kick%0d_count", i));
            chk($sformatf("kick%0d_to", i), {31'd0, wdg_to}, 32'd0);
        end
        // Rewriting EN=1 while enabled keeps the count
        idle(8);
        wr(2'd0, 32'd1);
        rd(2'd3, 32'd2, "en_rewrite_count");

        // Window: early kick at count 3 is a violation
        do_reset();
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd3);
        idle(12);
        rd(2'd3, 32'd3, "win_early_count");
        wr(2'd3, KEY);
        chk("win_early_to", {31'd0, wdg_to}, 32'd1);
        rd(2'd3, 32'd3, "win_early_frozen");

        // Window: kick at count 5 is accepted
        do_reset();
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd3);
        idle(20);
        rd(2'd3, 32'd5, "win_ok_count");
        wr(2'd3, KEY);
        rd(2'd3, 32'd0, "win_ok_after");
        chk("win_ok_to", {31'd0, wdg_to}, 32'd0);

        // Bad key while enabled -> immediate timeout; with EN=0 it is ignored
        do_reset();
        wr(2'd0, 32'd1);
        wr(2'd3, 32'd0);
        chk("badkey_en_to", {31'd0, wdg_to}, 32'd1);
        do_reset();
        wr(2'd3, 32'd0);
        chk("badkey_dis_to", {31'd0, wdg_to}, 32'd0);
        rd(2'd3, 32'd0, "badkey_dis_count");

        // Simultaneous read and write of one register returns the old value
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'd55;
        begin
            exp_t x;
            x.tag = "rw_same_old";
            x.val = 32'd1000;
            sb_q.push_back(x);
            idle(1);
            cfg_we = 1'b0; cfg_re = 1'b0;
            x = sb_q.pop_front();
            chk(x.tag, cfg_rdata, x.val);
        end
        rd(2'd1, 32'd55, "rw_same_new");

        // LOCK blocks config writes, kicks still work, reset clears it
        do_reset();
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd7);
        wr(2'd0, 32'd0);
        rd(2'd1, 32'd1000, "lock_timeout");
        rd(2'd0, 32'd5, "lock_ctrl");
        idle(8);
        rd(2'd3, 32'd3, "lock_count");
        wr(2'd3, KEY);
        rd(2'd3, 32'd0, "lock_kick_count");
        chk("lock_to", {31'd0, wdg_to}, 32'd0);
        do_reset();
        rd(2'd0, 32'd0, "unlock_ctrl");
        wr(2'd1, 32'd7);
        rd(2'd1, 32'd7, "unlock_timeout");

        // TIMEOUT written below the current count times out on the next tick
        wr(2'd1, 32'd1000);
        wr(2'd0, 32'd1);
        idle(11);
        wr(2'd1, 32'd1);
        chk("lowto_pre", {31'd0, wdg_to}, 32'd0);
        idle(4);
        chk("lowto_post", {31'd0, wdg_to}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wdg_timer.md
# wdg_timer

Programmable watchdog timer that produces the `wdg_to` timeout consumed by the reset controller, closing the timeout/recovery loop between CPU and reset logic. Software configures and kicks it through a simple single-cycle register port. A missed, early or corrupted kick raises a sticky timeout that holds until the block is reset. The reset controller's `wdg_res_n` is inverted at integration to drive `sys_res`.

## Interface
- `CNT_W`, 32: width of tick counter, TIMEOUT and WINDOW registers (≤32).
- `PRESCALE`, 1024: clock cycles per watchdog tick (≥1).
- `DEFAULT_TIMEOUT`, 32'd1000: TIMEOUT reset value.
- `WARN_TICKS`, 16: ticks before timeout at which `warn` rises.
- `KICK_KEY`, 32'hA5C3_5A3C: only valid kick data word.
- `clk`  in  1  system clock, all logic on rising edge.
- `sys_res`  in  1  synchronous reset, active-high; reset is synchronous and active-high.
- `cfg_we`  in  1  register write strobe, one write per asserted cycle.
- `cfg_re`  in  1  register read strobe.
- `cfg_addr`  in  2  register select.
- `cfg_wdata`  in  32  write data.
- `cfg_rdata`  out  32  read data, registered.
- `warn`  out  1  pre-timeout warning level.
- `wdg_to`  out  1  timeout, sticky level.

## Operation
- Registers: 0 CTRL {29'b0, LOCK, WIN_EN, EN}; 1 TIMEOUT[CNT_W-1:0]; 2 WINDOW[CNT_W-1:0]; 3 KICK (write) / current count (read). Upper unused bits read 0.
- Reset values: EN=WIN_EN=LOCK=0, TIMEOUT=DEFAULT_TIMEOUT, WINDOW=0, cnt=0, prescaler=0, `wdg_to`=0, `cfg_rdata`=0, `warn`=0.
- LOCK is set-only; once 1, writes to addr 0–2 are ignored until `sys_res`. KICK remains writable.
- Writing CTRL with EN=0 clears cnt and prescaler; rewriting EN=1 while already enabled does not clear them.
- Prescaler: when EN=1 and `wdg_to`=0, counts 0..PRESCALE-1; tick = prescaler at PRESCALE-1 (wraps to 0).
- On tick: if cnt ≥ TIMEOUT, set `wdg_to`; else cnt <= cnt+1. cnt therefore never wraps. A TIMEOUT write below current cnt causes timeout on the next tick.
- Kick = write addr 3 while EN=1 and `wdg_to`=0:
  - data == KICK_KEY and (WIN_EN=0 or cnt ≥ WINDOW): valid; cnt and prescaler <= 0.
  - data != KICK_KEY, or WIN_EN=1 with cnt < WINDOW: violation; `wdg_to` set at that edge.
  - With EN=0, kick writes are ignored.
- Kick overrides tick in the same cycle. A valid kick on the cycle that would time out prevents timeout.
- Once `wdg_to`=1: counter, prescaler and all writes are frozen; reads still work; only `sys_res` clears it.
- `warn` = EN & ~`wdg_to` & (cnt + WARN_TICKS ≥ TIMEOUT), evaluated in CNT_W+1 bits so there is no overflow. It is combinational from registered state and clears on a valid kick.

## Timing
- Write takes effect at the rising edge where `cfg_we`=1.
- Read: `cfg_rdata` is valid the cycle after `cfg_re` and holds until the next read. Simultaneous read/write to one address returns the pre-write value.
- EN written at edge E0: first tick at E0+PRESCALE, and `wdg_to` rises at edge E0+(TIMEOUT+1)·PRESCALE if there is no kick.
- Violation kick: `wdg_to` is high immediately after the write edge (zero extra latency).
- `sys_res` mid-count or mid-timeout returns all state to reset values at that edge.

## Test plan
- Reset, read all four registers -> CTRL=0, TIMEOUT=1000, WINDOW=0, count=0; `wdg_to`=`warn`=0.
- PRESCALE=4, TIMEOUT=3, write CTRL=1 at edge E0, no kick -> `wdg_to` rises at E0+16; `warn` (WARN_TICKS=2) high from E0+4; count reads 3; `wdg_to` stays high until `sys_res`.
- TIMEOUT=10, valid KICK_KEY kick every 30 cycles (PRESCALE=4) for 1000 cycles -> `wdg_to` never asserts; count returns to 0 after each kick.
- WIN_EN=1, WINDOW=5: kick at count=3 -> `wdg_to` next edge. Repeat after reset, kick at count=5 -> count=0, no timeout.
- Kick with 32'h0 while EN=1 -> immediate `wdg_to`. Same write with EN=0 -> ignored.
- Set LOCK, then write TIMEOUT=7 and CTRL=0 -> TIMEOUT and CTRL unchanged. Valid kick still accepted. `sys_res` then clears LOCK.
